approx_addsub_pipe: RTL and testbench

//  Pipelined, runtime-configurable approximate adder/subtractor. Next generation of the

---
 rtl/approx_addsub_pipe.sv | 114 +++++++++++
 tb/tb_approx_addsub_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_addsub_pipe.sv
// Two-stage approximate add/sub: LOA-style lower part of runtime length, exact upper part.
// An exact shadow sum flags every result that differs and feeds a saturating error counter.
module approx_addsub_pipe #(
  parameter int W       = 16,
  parameter int LPL_MAX = 8,
  parameter int CNT_W   = 16,
  localparam int LW     = $clog2(LPL_MAX + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_add_sub,
  input  logic [W-1:0]     i_in1,
  input  logic [W-1:0]     i_in2,
  input  logic [LW-1:0]    i_lpl,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [W:0]       o_res,
  output logic             o_err_flag,
  output logic [CNT_W-1:0] o_err_cnt,
  input  logic             i_clr_cnt
);

  // r_vld_pipe[1] = S1 occupied, r_vld_pipe[2] = S2 occupied (out_valid)
  logic [2:1]       r_vld_pipe;
  logic [W-1:0]     r_s1_a;
  logic [W-1:0]     r_s1_b;
  logic [LW-1:0]    r_s1_l;
  logic [W:0]       r_res;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_out_xfer;
  logic [W-1:0]     w_in2s;
  logic [LW-1:0]    w_l_clamp;
  logic [W:0]       w_a;
  logic [W:0]       w_b;
  logic [W:0]       w_lo_mask;
  logic [W:0]       w_top_lo;
  logic             w_c;
  logic [W:0]       w_cin;
  logic [W:0]       w_hi;
  logic [W:0]       w_approx;
  logic [W:0]       w_exact;

  assign w_s2_load  = !r_vld_pipe[2] || i_out_ready;
  assign w_s1_load  = !r_vld_pipe[1] || w_s2_load;
  assign w_out_xfer = r_vld_pipe[2] && i_out_ready;
  assign o_in_ready = w_s1_load;

  assign w_in2s    = i_add_sub ? (~i_in2 + W'(1)) : i_in2;
  assign w_l_clamp = (i_lpl > LW'(LPL_MAX)) ? LW'(LPL_MAX) : i_lpl;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_pipe[1] <= 1'b0;
      r_s1_a        <= '0;
      r_s1_b        <= '0;
      r_s1_l        <= '0;
    end else if (w_s1_load) begin
      r_vld_pipe[1] <= i_in_valid;
      if (i_in_valid) begin
        r_s1_a <= i_in1;
        r_s1_b <= w_in2s;
        r_s1_l <= w_l_clamp;
      end
    end
  end

  // Lower L bits are OR'd; bit L-1's AND becomes the carry into the exact upper adder.
  // w_top_lo isolates bit L-1 of the mask, so L=0 naturally yields no carry and no OR part.
  assign w_a       = {1'b0, r_s1_a};
  assign w_b       = {1'b0, r_s1_b};
  assign w_lo_mask = ~({(W+1){1'b1}} << r_s1_l);
  assign w_top_lo  = w_lo_mask ^ (w_lo_mask >> 1);
  assign w_c       = |(w_a & w_b & w_top_lo);
  assign w_cin     = w_c ? (w_top_lo << 1) : '0;
  assign w_hi      = (w_a & ~w_lo_mask) + (w_b & ~w_lo_mask) + w_cin;
  assign w_approx  = w_hi | ((w_a | w_b) & w_lo_mask);
  assign w_exact   = w_a + w_b;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_pipe[2] <= 1'b0;
      r_res         <= '0;
      r_err         <= 1'b0;
    end else if (w_s2_load) begin
      r_vld_pipe[2] <= r_vld_pipe[1];
      if (r_vld_pipe[1]) begin
        r_res <= w_approx;
        r_err <= (w_approx != w_exact);
      end
    end
  end

  // Clear wins over a coincident erroneous transfer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_clr_cnt)
      r_cnt <= '0;
    else if (w_out_xfer && r_err && !(&r_cnt))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_out_valid = r_vld_pipe[2];
  assign o_res       = r_res;
  assign o_err_flag  = r_err;
  assign o_err_cnt   = r_cnt;

endmodule

// File: tb/tb_approx_addsub_pipe.sv
// Bench for approx_addsub_pipe: queue-based scoreboard with an arithmetic model, two DUTs
// (16-bit and 4-bit error counters) sharing one stimulus stream.
module tb_approx_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        add_sub = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic [3:0]  lpl = '0;

  logic        in_ready, out_valid, err_flag;
  logic [16:0] res;
  logic [15:0] err_cnt;
  logic        in_ready2, out_valid2, err_flag2;
  logic [16:0] res2;
  logic [3:0]  err_cnt2;

  int total = 0;
  int bad = 0;
  int ec = 0;
  int mcnt = 0;
  int mcnt4 = 0;

  typedef struct {
    logic [16:0] res;
    logic        err;
    int          vis;
  } ent_t;
  ent_t q[$];

  approx_addsub_pipe #(.W(16), .LPL_MAX(8), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_add_sub(add_sub), .i_in1(in1), .i_in2(in2), .i_lpl(lpl),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_res(res),
    .o_err_flag(err_flag), .o_err_cnt(err_cnt), .i_clr_cnt(clr_cnt));

  approx_addsub_pipe #(.W(16), .LPL_MAX(8), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready2),
    .i_add_sub(add_sub), .i_in1(in1), .i_in2(in2), .i_lpl(lpl),
    .o_out_valid(out_valid2), .i_out_ready(out_ready), .o_res(res2),
    .o_err_flag(err_flag2), .o_err_cnt(err_cnt2), .i_clr_cnt(clr_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {err, res} from plain integer arithmetic.
  function automatic logic [17:0] model(input int a, input int b, input bit sub, input int l);
    int bs, L, exact, lo, c, hi, r;
    bs = sub ? ((65536 - b) % 65536) : b;
    L = (l > 8) ? 8 : l;
    exact = a + bs;
    if (L == 0) r = exact;
    else begin
      lo = (a | bs) % (1 << L);
      c  = ((a >> (L - 1)) & 1) & ((bs >> (L - 1)) & 1);
      hi = (a >> L) + (bs >> L) + c;
      r  = hi * (1 << L) + lo;
    end
    model = {(r != exact), 17'(r)};
  endfunction

  // Scoreboard: expected out_valid/in_ready from occupancy, results from the model queue.
  always @(negedge clk) begin
    bit   exp_ov, exp_ir;
    ent_t e, f;
    logic [17:0] m;
    if (ec > 0) begin
      exp_ov = (q.size() > 0) && (ec >= q[0].vis);
      exp_ir = !exp_ov || out_ready || (q.size() < 2);
      chk("out_valid", out_valid, exp_ov);
      chk("out_valid4", out_valid2, exp_ov);
      chk("in_ready", in_ready, exp_ir);
      chk("in_ready4", in_ready2, exp_ir);
      chk("err_cnt", err_cnt, mcnt);
      chk("err_cnt4", err_cnt2, mcnt4);
      if (exp_ov) begin
        chk("res", res, q[0].res);
        chk("err_flag", err_flag, q[0].err);
        chk("res4", res2, q[0].res);
        chk("err_flag4", err_flag2, q[0].err);
      end
      if (!rst_n) begin
        q.delete();
        mcnt = 0;
        mcnt4 = 0;
      end else begin
        if (exp_ov && out_ready) begin
          e = q.pop_front();
          if (e.err) begin
            if (mcnt < 65535) mcnt++;
            if (mcnt4 < 15) mcnt4++;
          end
          if (q.size() > 0) begin
            f = q.pop_front();
            if (f.vis < ec + 1) f.vis = ec + 1;
            q.push_front(f);
          end
        end
        if (clr_cnt) begin
          mcnt = 0;
          mcnt4 = 0;
        end
        if (in_valid && exp_ir) begin
          m = model(int'(in1), int'(in2), add_sub, int'(lpl));
          e.res = m[16:0];
          e.err = m[17];
          e.vis = ec + 2;
          q.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input bit sub, input logic [3:0] l);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in1 = a; in2 = b; add_sub = sub; lpl = l;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] ba [4];
    int idx;
    // Model pinned by hand-computed values.
    chk("model_exact_add", 32'(model(32'h1234, 32'h0FFF, 1'b0, 0)), 32'h02233);
    chk("model_lpl4_add", 32'(model(32'h000F, 32'h0001, 1'b0, 4)), 32'h2000F);
    chk("model_lpl4_sub", 32'(model(32'h0010, 32'h0001, 1'b1, 4)), 32'h1000F);
    chk("model_clamp", 32'(model(32'h00FF, 32'h0001, 1'b0, 12)), 32'h200FF);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_res", res, 17'h0);
    chk("rst_err_cnt", err_cnt, 16'h0);

    // Exact add, approximate add/sub, clamped lpl
    out_ready = 1'b1;
    send(16'h1234, 16'h0FFF, 1'b0, 4'd0);
    chk("lat_a", out_valid, 1'b0);
    step();
    chk("lat_b", out_valid, 1'b1);
    chk("lat_res", res, 17'h02233);
    send(16'h000F, 16'h0001, 1'b0, 4'd4);
    send(16'h0010, 16'h0001, 1'b1, 4'd4);
    send(16'h00FF, 16'h0001, 1'b0, 4'd12);
    repeat (4) step();

    // Backpressure: 4 beats offered while out_ready is low for 6 cycles
    ba[0] = 16'h0101; ba[1] = 16'h0202; ba[2] = 16'h0303; ba[3] = 16'h0404;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in1 = ba[idx]; in2 = 16'h00FF; add_sub = 1'b0; lpl = 4'd3;
      @(negedge clk);
      if (in_ready && idx < 3) idx++;
      step();
    end
    chk("stall_accepted", 32'(idx), 32'd2);
    chk("stall_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      in_valid = 1'b1; in1 = ba[idx];
      @(negedge clk);
      if (in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    chk("stall_all_sent", 32'(idx), 32'd4);
    repeat (4) step();
    chk("stall_drained", 32'(q.size()), 32'd0);

    // Saturation of the narrow counter, then clear coincident with an erroneous transfer
    for (int i = 0; i < 20; i++) send(16'h000F, 16'h0001, 1'b0, 4'd4);
    repeat (4) step();
    chk("sat_cnt4", err_cnt2, 4'hF);
    send(16'h000F, 16'h0001, 1'b0, 4'd4);
    for (int i = 0; i < 10 && !out_valid; i++) step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_prio", err_cnt, 16'h0);
    chk("clr_prio4", err_cnt2, 4'h0);

    // Reset with both stages full
    out_ready = 1'b0;
    send(16'h000F, 16'h0001, 1'b0, 4'd4);
    send(16'h000F, 16'h0001, 1'b0, 4'd4);
    step();
    chk("full_out_valid", out_valid, 1'b1);
    chk("full_in_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst2_out_valid", out_valid, 1'b0);
    chk("rst2_err_cnt", err_cnt, 16'h0);
    chk("rst2_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    send(16'h1234, 16'h0FFF, 1'b0, 4'd0);
    chk("rst2_lat_a", out_valid, 1'b0);
    step();
    chk("rst2_lat_b", out_valid, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      add_sub   = 1'($urandom);
      in1       = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      in2       = 16'($urandom);
      lpl       = 4'($urandom_range(0, 15));
      clr_cnt   = ($urandom_range(0, 49) == 0);
      step();
    end
    in_valid = 1'b0;
    clr_cnt = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
